pwm_capture: RTL

- PWM receiver/decoder, the measuring end of the PWM link driven by the duty-cycle generator.
- Samples an external PWM line and measures period and high time in system-clock cycles.
- Computes the integer duty cycle in percent (0..100) and flags a stuck (edgeless) line.
- Sits beside the generator for loopback self-check and reads external servo/PWM sources at 50 MHz.

---
 rtl/pwm_capture_if.sv | 24 ++
 rtl/pwm_capture.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM line input and measurement results of the PWM capture block.
// slave  = the capture block (reads pwm_in, drives results)
// master = whoever drives the PWM line and consumes the results
interface pwm_capture_if #(
    parameter int unsigned CNT_W = 32
);
    logic             pwm_in;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [6:0]       duty_pct;
    logic             valid;
    logic             timeout;
    logic             overrun;

    modport master (
        output pwm_in,
        input  period_cnt, high_cnt, duty_pct, valid, timeout, overrun
    );

    modport slave (
        input  pwm_in,
        output period_cnt, high_cnt, duty_pct, valid, timeout, overrun
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: PWM receiver. Measures period and high time of pwm_in in clk
// cycles, derives floor(high*100/period) with a sequential restoring divider,
// and flags a stuck (edgeless) line after TIMEOUT cycles.
// Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 2_000_000,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    pwm_capture_if.slave  bus
);
    localparam int unsigned DW = CNT_W + 7;          // dividend width (high*100)
    localparam int unsigned BW = $clog2(DW + 1);     // divider step counter width

    typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

    state_t           state, state_n;
    logic             sync1, sync2;
    logic             lvl, lvl_q;
    logic             rise, fall, any_edge;
    logic [CNT_W-1:0] idle_cnt;
    logic             tmo_hit;
    logic             cnt_load, hi_latch, div_start, ovr_set;
    logic [CNT_W-1:0] cnt, high_tmp;

    logic             busy;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    dvd;
    logic [CNT_W-1:0] rem, p_hold, h_hold;
    logic [CNT_W:0]   rem_sh, diff;
    logic             qbit;
    logic [CNT_W-1:0] rem_nx;
    logic [DW-1:0]    quo_nx;
    logic [DW-1:0]    prod;

    logic [CNT_W-1:0] period_q, high_q;
    logic [6:0]       duty_q;
    logic             valid_q, tmo_q, ovr_q;

    // Two-stage synchronizer for the asynchronous PWM line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] stab_cnt;
    logic          flt_lvl;

    // Accept a new level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt <= '0;
            flt_lvl  <= 1'b0;
        end else if (sync2 == flt_lvl) begin
            stab_cnt <= '0;
        end else if (stab_cnt == FW'(FILTER_LEN - 1)) begin
            flt_lvl  <= sync2;
            stab_cnt <= '0;
        end else begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    assign lvl = flt_lvl;
`else
    assign lvl = sync2;
`endif

    // Registered copy of the accepted level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lvl_q <= 1'b0;
        else     lvl_q <= lvl;
    end

    assign rise     = lvl & ~lvl_q;
    assign fall     = ~lvl & lvl_q;
    assign any_edge = rise | fall;

    // Fires exactly once: on the cycle the idle counter would reach TIMEOUT
    assign tmo_hit = ~any_edge && (idle_cnt == CNT_W'(TIMEOUT - 1));

    // Idle counter: reloads on any edge, saturates at TIMEOUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               idle_cnt <= '0;
        else if (any_edge)                     idle_cnt <= '0;
        else if (idle_cnt != CNT_W'(TIMEOUT))  idle_cnt <= idle_cnt + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // FSM next state and measurement strobes
    always_comb begin
        state_n   = state;
        cnt_load  = 1'b0;
        hi_latch  = 1'b0;
        div_start = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    cnt_load = 1'b1;
                    state_n  = MEAS_HIGH;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    hi_latch = 1'b1;
                    state_n  = MEAS_LOW;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    cnt_load = 1'b1;
                    state_n  = MEAS_HIGH;
                    if (busy) ovr_set   = 1'b1;
                    else      div_start = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (tmo_hit) state_n = IDLE;
    end

    // Period counter and latched high time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            high_tmp <= '0;
        end else begin
            if (cnt_load)           cnt <= CNT_W'(1);
            else if (state != IDLE) cnt <= cnt + 1'b1;
            if (hi_latch)           high_tmp <= cnt;
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        prod   = DW'(high_tmp) * DW'(100);
        rem_sh = {rem, dvd[DW-1]};
        diff   = rem_sh - {1'b0, p_hold};
        qbit   = ~diff[CNT_W];
        rem_nx = qbit ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
        quo_nx = {dvd[DW-2:0], qbit};
    end

    // Divider sequencing and result registers; a timeout aborts any divide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            bit_cnt  <= '0;
            dvd      <= '0;
            rem      <= '0;
            p_hold   <= '0;
            h_hold   <= '0;
            period_q <= '0;
            high_q   <= '0;
            duty_q   <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ovr_q   <= ovr_set;
            if (any_edge) tmo_q <= 1'b0;
            if (tmo_hit) begin
                busy     <= 1'b0;
                tmo_q    <= 1'b1;
                period_q <= '0;
                high_q   <= '0;
                duty_q   <= lvl ? 7'd100 : 7'd0;
                valid_q  <= 1'b1;
            end else if (div_start) begin
                busy    <= 1'b1;
                bit_cnt <= BW'(DW);
                dvd     <= prod;
                rem     <= '0;
                p_hold  <= cnt;
                h_hold  <= high_tmp;
            end else if (busy) begin
                dvd     <= quo_nx;
                rem     <= rem_nx;
                bit_cnt <= bit_cnt - 1'b1;
                if (bit_cnt == BW'(1)) begin
                    busy     <= 1'b0;
                    period_q <= p_hold;
                    high_q   <= h_hold;
                    duty_q   <= quo_nx[6:0];
                    valid_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.period_cnt = period_q;
    assign bus.high_cnt   = high_q;
    assign bus.duty_pct   = duty_q;
    assign bus.valid      = valid_q;
    assign bus.timeout    = tmo_q;
    assign bus.overrun    = ovr_q;

endmodule
